// File: rtl/clock_div_cfg_pkg.sv
// Shared types and constants for the clock divider reconfiguration sequencer.
package clock_div_cfg_pkg;

    localparam int unsigned MF_WIDTH = 8;

    localparam logic [MF_WIDTH-1:0] DEFAULT_MFI = 8'h2;
    localparam logic [MF_WIDTH-1:0] DEFAULT_MFN = 8'h3;
    localparam logic [MF_WIDTH-1:0] DEFAULT_MFD = 8'h5;

    typedef enum logic [2:0] {
        StIdle,
        StStop,
        StUpdate,
        StRelease,
        StRestart,
        StFault
    } cfg_seq_state_t;

    // A fractional divider needs a non-zero denominator and a proper fraction.
    function automatic logic mf_cfg_ok(input logic [MF_WIDTH-1:0] mfn,
                                       input logic [MF_WIDTH-1:0] mfd);
        return (mfd != '0) && (mfn < mfd);
    endfunction

endpackage

// File: rtl/clock_div_ack_sync.sv
// Multi-flop synchronizer bringing async_update_ack into the sequencer clock domain.
module clock_div_ack_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic async_reset,
    input  logic async_in,
    output logic sync_out
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clock or posedge async_reset) begin
        if (async_reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
        end
    end

    assign sync_out = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/clock_divider_config_sequencer.sv
// Sequences a safe MFI/MFN/MFD update: stop the node clock, handshake the update
// into the divider domain, then hand the clock request back to the user.
module clock_divider_config_sequencer
    import clock_div_cfg_pkg::*;
#(
    parameter int unsigned          SYNC_STAGES    = 2,
    parameter int unsigned          TIMEOUT_CYCLES = 1023,
    parameter logic [MF_WIDTH-1:0]  RESET_MFI      = DEFAULT_MFI,
    parameter logic [MF_WIDTH-1:0]  RESET_MFN      = DEFAULT_MFN,
    parameter logic [MF_WIDTH-1:0]  RESET_MFD      = DEFAULT_MFD
) (
    input  logic                clock,
    input  logic                async_reset,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [MF_WIDTH-1:0] cfg_mfi,
    input  logic [MF_WIDTH-1:0] cfg_mfn,
    input  logic [MF_WIDTH-1:0] cfg_mfd,
    input  logic                user_request,
    output logic                node_request,
    input  logic                node_ready,
    input  logic                node_silent,
    output logic                async_update,
    output logic [MF_WIDTH-1:0] mfi,
    output logic [MF_WIDTH-1:0] mfn,
    output logic [MF_WIDTH-1:0] mfd,
    input  logic                async_update_ack,
    output logic                busy,
    output logic                cfg_done,
    output logic                cfg_error
);

    localparam int unsigned        CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]   TMO_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]   TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    cfg_seq_state_t      r_state;
    cfg_seq_state_t      w_state_next;
    logic [CNT_W-1:0]    r_tmo_cnt;
    logic [CNT_W-1:0]    w_tmo_cnt_next;
    logic                r_async_update;
    logic                r_cfg_done;
    logic                r_cfg_error;
    logic [MF_WIDTH-1:0] r_mfi;
    logic [MF_WIDTH-1:0] r_mfn;
    logic [MF_WIDTH-1:0] r_mfd;

    logic w_ack_sync;
    logic w_xfer;
    logic w_cfg_ok;
    logic w_tmo_hit;
    logic w_waiting;

    clock_div_ack_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clock       (clock),
        .async_reset (async_reset),
        .async_in    (async_update_ack),
        .sync_out    (w_ack_sync)
    );

    assign w_xfer    = cfg_valid && (r_state == StIdle);
    assign w_cfg_ok  = mf_cfg_ok(cfg_mfn, cfg_mfd);
    // This cycle is the last one the current wait state is allowed to occupy.
    assign w_tmo_hit = (r_tmo_cnt >= TMO_LAST);
    assign w_waiting = (r_state == StStop) || (r_state == StUpdate) ||
                       (r_state == StRelease) || (r_state == StRestart);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (w_xfer && w_cfg_ok) w_state_next = StStop;
            end
            StStop: begin
                if (node_silent)     w_state_next = StUpdate;
                else if (w_tmo_hit)  w_state_next = StFault;
            end
            StUpdate: begin
                if (w_ack_sync)      w_state_next = StRelease;
                else if (w_tmo_hit)  w_state_next = StFault;
            end
            StRelease: begin
                if (!w_ack_sync)     w_state_next = StRestart;
                else if (w_tmo_hit)  w_state_next = StFault;
            end
            StRestart: begin
                if (!user_request || node_ready) w_state_next = StIdle;
                else if (w_tmo_hit)              w_state_next = StFault;
            end
            StFault: begin
                if (!w_ack_sync)     w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_tmo_cnt_next = r_tmo_cnt;
        if (w_state_next != r_state) begin
            w_tmo_cnt_next = '0;
        end else if (w_waiting && (r_tmo_cnt != TMO_MAX)) begin
            w_tmo_cnt_next = r_tmo_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge async_reset) begin
        if (async_reset) begin
            r_state        <= StIdle;
            r_tmo_cnt      <= '0;
            r_async_update <= 1'b0;
            r_cfg_done     <= 1'b0;
            r_cfg_error    <= 1'b0;
            r_mfi          <= RESET_MFI;
            r_mfn          <= RESET_MFN;
            r_mfd          <= RESET_MFD;
        end else begin
            r_state        <= w_state_next;
            r_tmo_cnt      <= w_tmo_cnt_next;
            r_async_update <= (w_state_next == StUpdate);
            r_cfg_done     <= (r_state == StRestart) && (w_state_next == StIdle);
            if (w_xfer) begin
                r_cfg_error <= !w_cfg_ok;
            end else if ((w_state_next == StFault) && (r_state != StFault)) begin
                r_cfg_error <= 1'b1;
            end
            if (w_xfer && w_cfg_ok) begin
                r_mfi <= cfg_mfi;
                r_mfn <= cfg_mfn;
                r_mfd <= cfg_mfd;
            end
        end
    end

    // The node keeps following the user only while no update is in flight.
    assign node_request = ((r_state == StIdle) || (r_state == StRestart)) ? user_request : 1'b0;
    assign cfg_ready    = (r_state == StIdle);
    assign busy         = (r_state != StIdle);
    assign async_update = r_async_update;
    assign cfg_done     = r_cfg_done;
    assign cfg_error    = r_cfg_error;
    assign mfi          = r_mfi;
    assign mfn          = r_mfn;
    assign mfd          = r_mfd;

endmodule

// File: tb/tb_clock_divider_config_sequencer.sv
// Directed bench for clock_divider_config_sequencer with a registered node/ack responder.
module tb_clock_divider_config_sequencer;

    logic       clock = 1'b0;
    logic       async_reset = 1'b1;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [7:0] cfg_mfi = '0;
    logic [7:0] cfg_mfn = '0;
    logic [7:0] cfg_mfd = '0;
    logic       user_request = 1'b1;
    logic       node_request;
    logic       node_ready;
    logic       node_silent;
    logic       async_update;
    logic [7:0] mfi;
    logic [7:0] mfn;
    logic [7:0] mfd;
    logic       async_update_ack;
    logic       busy;
    logic       cfg_done;
    logic       cfg_error;

    logic ack_en = 1'b1;
    logic ready_en = 1'b1;
    int   total = 0;
    int   bad = 0;

    clock_divider_config_sequencer #(
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clock            (clock),
        .async_reset      (async_reset),
        .cfg_valid        (cfg_valid),
        .cfg_ready        (cfg_ready),
        .cfg_mfi          (cfg_mfi),
        .cfg_mfn          (cfg_mfn),
        .cfg_mfd          (cfg_mfd),
        .user_request     (user_request),
        .node_request     (node_request),
        .node_ready       (node_ready),
        .node_silent      (node_silent),
        .async_update     (async_update),
        .mfi              (mfi),
        .mfn              (mfn),
        .mfd              (mfd),
        .async_update_ack (async_update_ack),
        .busy             (busy),
        .cfg_done         (cfg_done),
        .cfg_error        (cfg_error)
    );

    always #5 clock = ~clock;

    // Node and divider-domain responder, each reacting one cycle late.
    always @(posedge clock or posedge async_reset) begin
        if (async_reset) begin
            node_silent      <= 1'b0;
            node_ready       <= 1'b0;
            async_update_ack <= 1'b0;
        end else begin
            node_silent      <= !node_request;
            node_ready       <= node_request & ready_en;
            async_update_ack <= async_update & ack_en;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic offer(input logic [7:0] i, input logic [7:0] n, input logic [7:0] d);
        cfg_mfi = i;
        cfg_mfn = n;
        cfg_mfd = d;
        cfg_valid = 1'b1;
    endtask

    task automatic test_reset();
        async_reset = 1'b1;
        step();
        step();
        chk("reset_ready_in_reset", 32'(cfg_ready), 32'd1);
        async_reset = 1'b0;
        step();
        chk("reset_ready", 32'(cfg_ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_update", 32'(async_update), 32'd0);
        chk("reset_done", 32'(cfg_done), 32'd0);
        chk("reset_error", 32'(cfg_error), 32'd0);
        chk("reset_mf", 32'({mfi, mfn, mfd}), 32'h020305);
        chk("reset_node_req", 32'(node_request), 32'd1);
    endtask

    task automatic test_invalid_config();
        offer(8'h7, 8'h0, 8'h0);
        step();
        cfg_valid = 1'b0;
        chk("inv_mfd0_error", 32'(cfg_error), 32'd1);
        chk("inv_mfd0_busy", 32'(busy), 32'd0);
        chk("inv_mfd0_mf", 32'({mfi, mfn, mfd}), 32'h020305);
        step();
        offer(8'h1, 8'h5, 8'h5);
        step();
        cfg_valid = 1'b0;
        chk("inv_eq_error", 32'(cfg_error), 32'd1);
        chk("inv_eq_busy", 32'(busy), 32'd0);
        chk("inv_eq_ready", 32'(cfg_ready), 32'd1);
        chk("inv_eq_mf", 32'({mfi, mfn, mfd}), 32'h020305);
    endtask

    task automatic test_basic_sequence();
        int first_upd = -1;
        int upd_cnt = 0;
        int done_cnt = 0;
        int done_k = -1;
        int idle_k = -1;
        user_request = 1'b1;
        step();
        offer(8'h4, 8'h1, 8'h3);
        step();
        cfg_valid = 1'b0;
        chk("basic_busy_t1", 32'(busy), 32'd1);
        chk("basic_node_req_t1", 32'(node_request), 32'd0);
        chk("basic_error_cleared", 32'(cfg_error), 32'd0);
        chk("basic_mf_t1", 32'({mfi, mfn, mfd}), 32'h040103);
        for (int k = 2; k <= 20; k++) begin
            step();
            if (async_update) begin
                if (first_upd < 0) first_upd = k;
                upd_cnt++;
            end
            if (cfg_done) begin
                done_cnt++;
                done_k = k;
            end
            if (!busy && idle_k < 0) idle_k = k;
        end
        chk("basic_update_start", 32'(first_upd), 32'd3);
        chk("basic_update_len", 32'(upd_cnt), 32'd4);
        chk("basic_done_count", 32'(done_cnt), 32'd1);
        chk("basic_done_cycle", 32'(done_k), 32'd13);
        chk("basic_idle_cycle", 32'(idle_k), 32'd13);
        chk("basic_mf_end", 32'({mfi, mfn, mfd}), 32'h040103);
    endtask

    task automatic test_timeout();
        int upd_cnt = 0;
        int last_upd = -1;
        int err_k = -1;
        int idle_k = -1;
        int done_cnt = 0;
        logic fault_nreq = 1'b1;
        ack_en = 1'b0;
        offer(8'h9, 8'h2, 8'h4);
        step();
        cfg_valid = 1'b0;
        chk("tmo_error_t1", 32'(cfg_error), 32'd0);
        for (int k = 2; k <= 30; k++) begin
            step();
            if (async_update) begin
                upd_cnt++;
                last_upd = k;
            end
            if (cfg_error && err_k < 0) err_k = k;
            if (!busy && idle_k < 0) idle_k = k;
            if (cfg_done) done_cnt++;
            if (k == 19) fault_nreq = node_request;
        end
        chk("tmo_update_len", 32'(upd_cnt), 32'd16);
        chk("tmo_update_drop", 32'(last_upd), 32'd18);
        chk("tmo_error_cycle", 32'(err_k), 32'd19);
        chk("tmo_fault_node_req", 32'(fault_nreq), 32'd0);
        chk("tmo_idle_cycle", 32'(idle_k), 32'd20);
        chk("tmo_no_done", 32'(done_cnt), 32'd0);
        chk("tmo_error_sticky", 32'(cfg_error), 32'd1);
        ack_en = 1'b1;
        step();
    endtask

    task automatic test_user_request();
        int nreq_hi = 0;
        int first_upd = -1;
        int done_k = -1;
        int idle_k = -1;
        logic busy15 = 1'b0;
        logic nreq15 = 1'b0;
        user_request = 1'b0;
        repeat (3) step();
        offer(8'h3, 8'h0, 8'h2);
        step();
        cfg_valid = 1'b0;
        if (node_request) nreq_hi++;
        for (int k = 2; k <= 20; k++) begin
            step();
            if (node_request) nreq_hi++;
            if (async_update && first_upd < 0) first_upd = k;
            if (cfg_done && done_k < 0) done_k = k;
            if (!busy && idle_k < 0) idle_k = k;
        end
        chk("ureq0_node_req_low", 32'(nreq_hi), 32'd0);
        chk("ureq0_update_start", 32'(first_upd), 32'd2);
        chk("ureq0_done_cycle", 32'(done_k), 32'd11);
        chk("ureq0_idle_cycle", 32'(idle_k), 32'd11);

        user_request = 1'b1;
        ready_en = 1'b0;
        done_k = -1;
        idle_k = -1;
        repeat (3) step();
        offer(8'h5, 8'h4, 8'h9);
        step();
        cfg_valid = 1'b0;
        for (int k = 2; k <= 25; k++) begin
            step();
            if (k == 15) begin
                busy15 = busy;
                nreq15 = node_request;
                ready_en = 1'b1;
            end
            if (cfg_done && done_k < 0) done_k = k;
            if (!busy && idle_k < 0) idle_k = k;
        end
        chk("ureq1_wait_busy", 32'(busy15), 32'd1);
        chk("ureq1_restart_req", 32'(nreq15), 32'd1);
        chk("ureq1_idle_cycle", 32'(idle_k), 32'd17);
        chk("ureq1_done_cycle", 32'(done_k), 32'd17);
    endtask

    task automatic test_back_to_back();
        int done_cnt = 0;
        int last_done = -1;
        logic [23:0] mf5 = '0;
        logic [23:0] mf11 = '0;
        logic [23:0] mf12 = '0;
        logic done11 = 1'b0;
        logic busy12 = 1'b0;
        user_request = 1'b0;
        repeat (3) step();
        offer(8'h1, 8'h0, 8'h1);
        step();
        chk("b2b_first_mf", 32'({mfi, mfn, mfd}), 32'h010001);
        offer(8'h6, 8'h3, 8'h7);
        for (int k = 2; k <= 30; k++) begin
            step();
            if (k == 5) mf5 = {mfi, mfn, mfd};
            if (k == 11) begin
                mf11 = {mfi, mfn, mfd};
                done11 = cfg_done;
            end
            if (k == 12) begin
                mf12 = {mfi, mfn, mfd};
                busy12 = busy;
                cfg_valid = 1'b0;
            end
            if (cfg_done) begin
                done_cnt++;
                last_done = k;
            end
        end
        chk("b2b_held_mf", 32'(mf5), 32'h010001);
        chk("b2b_first_done", 32'(done11), 32'd1);
        chk("b2b_idle_mf", 32'(mf11), 32'h010001);
        chk("b2b_second_busy", 32'(busy12), 32'd1);
        chk("b2b_second_mf", 32'(mf12), 32'h060307);
        chk("b2b_done_count", 32'(done_cnt), 32'd2);
        chk("b2b_second_done", 32'(last_done), 32'd22);
    endtask

    task automatic test_reset_mid_update();
        user_request = 1'b1;
        repeat (3) step();
        offer(8'h8, 8'h2, 8'h3);
        step();
        cfg_valid = 1'b0;
        repeat (3) step();
        chk("rst_mid_in_update", 32'(async_update), 32'd1);
        async_reset = 1'b1;
        step();
        chk("rst_mid_update", 32'(async_update), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_mf", 32'({mfi, mfn, mfd}), 32'h020305);
        chk("rst_mid_ready", 32'(cfg_ready), 32'd1);
        async_reset = 1'b0;
        step();
        chk("rst_mid_after_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        test_reset();
        test_invalid_config();
        test_basic_sequence();
        test_timeout();
        test_user_request();
        test_back_to_back();
        test_reset_mid_update();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
